// File: rtl/tcam_route_pkg.sv
// Shared types and default widths for the TCAM route memory.
package tcam_route_pkg;

   localparam int unsigned DEF_ID_WIDTH     = 4;
   localparam int unsigned DEF_DST_WIDTH    = 4;
   localparam int unsigned DEF_WEIGHT_WIDTH = 4;
   localparam int unsigned DEF_WORDS        = 16;

   typedef enum logic [1:0] {
      StIdle,
      StMatch,
      StEmit
   } state_e;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0]     key;
      logic [DEF_ID_WIDTH-1:0]     care;
      logic [DEF_DST_WIDTH-1:0]    dst;
      logic [DEF_WEIGHT_WIDTH-1:0] weight;
      logic                        vld;
   } tcam_entry_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-set-bit index plus any-set / exactly-one flags for a WORDS-bit vector.
module tcam_prio_enc #(
   parameter int unsigned WORDS = 16,
   parameter int unsigned AW    = $clog2(WORDS)
) (
   input  logic [WORDS-1:0] vec,
   output logic [AW-1:0]    idx,
   output logic             any,
   output logic             one
);

   always_comb begin
      idx = '0;
      for (int i = int'(WORDS) - 1; i >= 0; i--) begin
         if (vec[i]) idx = AW'(i);
      end
      any = |vec;
      // Clearing the lowest set bit leaves zero only for a single-hot vector.
      one = any && ((vec & (vec - WORDS'(1))) == '0);
   end

endmodule

// File: rtl/tcam_route_mem.sv
// TCAM routing table: ternary lookup, then one result beat per matching entry.
// Optional hit/miss counters are enabled with ROUTE_STATS_EN.
module tcam_route_mem
   import tcam_route_pkg::*;
#(
   parameter int unsigned ID_WIDTH     = DEF_ID_WIDTH,
   parameter int unsigned DST_WIDTH    = DEF_DST_WIDTH,
   parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int unsigned WORDS        = DEF_WORDS,
   parameter int unsigned AW           = $clog2(WORDS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [AW-1:0]           cfg_addr,
   input  logic [ID_WIDTH-1:0]     cfg_key,
   input  logic [ID_WIDTH-1:0]     cfg_care,
   input  logic [DST_WIDTH-1:0]    cfg_dst,
   input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
   input  logic                    cfg_vld,
   input  logic                    flush,
   input  logic                    pkt_valid,
   output logic                    pkt_ready,
   input  logic [ID_WIDTH-1:0]     pkt_id,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DST_WIDTH-1:0]    out_dst,
   output logic [WEIGHT_WIDTH-1:0] out_weight,
   output logic                    out_last,
   output logic                    out_miss
`ifdef ROUTE_STATS_EN
   ,
   output logic [15:0]             stat_pkts,
   output logic [15:0]             stat_miss
`endif
);

   typedef struct packed {
      logic [ID_WIDTH-1:0]     key;
      logic [ID_WIDTH-1:0]     care;
      logic [DST_WIDTH-1:0]    dst;
      logic [WEIGHT_WIDTH-1:0] weight;
      logic                    vld;
   } entry_t;

   entry_t                  mem_q [WORDS];
   state_e                  state_q, state_d;
   logic [ID_WIDTH-1:0]     key_q;
   logic [WORDS-1:0]        match, hit_q, hit_d;
   logic                    load;
   logic [DST_WIDTH-1:0]    beat_dst_q;
   logic [WEIGHT_WIDTH-1:0] beat_wt_q;
   logic                    last_q, miss_q;
   logic [AW-1:0]           nxt_idx;
   logic                    nxt_any, nxt_one;
   logic                    handshake;

   // Flush wins over a coincident write; entry payload is never reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(WORDS); i++) mem_q[i].vld <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < int'(WORDS); i++) mem_q[i].vld <= 1'b0;
      end else if (cfg_we) begin
         mem_q[cfg_addr] <= '{key: cfg_key, care: cfg_care, dst: cfg_dst,
                              weight: cfg_weight, vld: cfg_vld};
      end
   end

   always_comb begin
      for (int i = 0; i < int'(WORDS); i++) begin
         match[i] = mem_q[i].vld && (((key_q ^ mem_q[i].key) & mem_q[i].care) == '0);
      end
   end

   assign pkt_ready = (state_q == StIdle) && !rst;
   assign out_valid = (state_q == StEmit) && !rst;
   assign out_last  = out_valid && last_q;
   assign out_miss  = out_valid && miss_q;
   assign out_dst    = out_valid ? beat_dst_q : '0;
   assign out_weight = out_valid ? beat_wt_q  : '0;
   assign handshake = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      hit_d   = hit_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: if (pkt_valid) state_d = StMatch;
         StMatch: begin
            hit_d   = match;
            load    = 1'b1;
            state_d = StEmit;
         end
         StEmit: begin
            if (handshake) begin
               hit_d = hit_q & (hit_q - WORDS'(1));
               load  = 1'b1;
               if (last_q) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Encoder looks at the next hit vector so each beat is registered ahead of time.
   tcam_prio_enc #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_prio_enc (
      .vec (hit_d),
      .idx (nxt_idx),
      .any (nxt_any),
      .one (nxt_one)
   );

   always_ff @(posedge clk) begin
      if (state_q == StIdle && pkt_valid) key_q <= pkt_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         hit_q      <= '0;
         beat_dst_q <= '0;
         beat_wt_q  <= '0;
         last_q     <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         if (load) begin
            beat_dst_q <= nxt_any ? mem_q[nxt_idx].dst    : '0;
            beat_wt_q  <= nxt_any ? mem_q[nxt_idx].weight : '0;
            last_q     <= nxt_one || !nxt_any;
            miss_q     <= !nxt_any;
         end
      end
   end

`ifdef ROUTE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkts <= '0;
         stat_miss <= '0;
      end else begin
         if (pkt_valid && pkt_ready && stat_pkts != 16'hFFFF) stat_pkts <= stat_pkts + 16'd1;
         if (handshake && out_miss && stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tcam_route_mem.sv
// Self-checking bench for tcam_route_mem: directed scenarios plus randomized traffic
// checked against a beat-list reference model.
module tb_tcam_route_mem;
   import tcam_route_pkg::*;

   logic       clk = 1'b0;
   logic       rst, cfg_we, cfg_vld, flush, pkt_valid, pkt_ready;
   logic [3:0] cfg_addr, cfg_key, cfg_care, cfg_dst, cfg_weight, pkt_id;
   logic       out_valid, out_ready, out_last, out_miss;
   logic [3:0] out_dst, out_weight;
`ifdef ROUTE_STATS_EN
   logic [15:0] stat_pkts, stat_miss;
`endif

   always #5 clk = ~clk;

   tcam_route_mem dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_key    (cfg_key),
      .cfg_care   (cfg_care),
      .cfg_dst    (cfg_dst),
      .cfg_weight (cfg_weight),
      .cfg_vld    (cfg_vld),
      .flush      (flush),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_id     (pkt_id),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_dst    (out_dst),
      .out_weight (out_weight),
      .out_last   (out_last),
      .out_miss   (out_miss)
`ifdef ROUTE_STATS_EN
      ,
      .stat_pkts  (stat_pkts),
      .stat_miss  (stat_miss)
`endif
   );

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: table contents plus the list of beats still owed for the packet.
   typedef struct {
      int idx;
      int dst;
      int wt;
      bit miss;
   } beat_t;

   tcam_entry_t m_tab [16];
   beat_t       beats [$];
   logic [3:0]  m_key;
   int          phase = 0;   // 0 idle, 1 lookup pending, 2 emitting
   bit          armed = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) m_tab[i].vld = 1'b0;
         beats.delete();
         phase = 0;
         armed = 1'b1;
      end else begin
         if (phase == 2) begin
            if (out_ready) begin
               void'(beats.pop_front());
               if (beats.size() == 0) phase = 0;
            end
         end else if (phase == 1) begin
            for (int i = 0; i < 16; i++) begin
               if (m_tab[i].vld && (((m_key ^ m_tab[i].key) & m_tab[i].care) == 4'h0))
                  beats.push_back('{i, int'(m_tab[i].dst), int'(m_tab[i].weight), 1'b0});
            end
            if (beats.size() == 0) beats.push_back('{0, 0, 0, 1'b1});
            phase = 2;
         end else if (pkt_valid) begin
            m_key = pkt_id;
            phase = 1;
         end
         if (flush) begin
            for (int i = 0; i < 16; i++) m_tab[i].vld = 1'b0;
         end else if (cfg_we) begin
            m_tab[cfg_addr] = '{key: cfg_key, care: cfg_care, dst: cfg_dst,
                                weight: cfg_weight, vld: cfg_vld};
         end
      end
   end

   always @(negedge clk) begin
      bit ev, er;
      if (armed) begin
         ev = !rst && phase == 2;
         er = !rst && phase == 0;
         chk("pkt_ready", 16'(pkt_ready), 16'(er));
         chk("out_valid", 16'(out_valid), 16'(ev));
         if (ev && beats.size() > 0) begin
            chk("out_dst",    16'(out_dst),    16'(beats[0].dst));
            chk("out_weight", 16'(out_weight), 16'(beats[0].wt));
            chk("out_last",   16'(out_last),   16'(beats.size() == 1));
            chk("out_miss",   16'(out_miss),   16'(beats[0].miss));
         end
      end
   end

   function automatic bit pending(input logic [3:0] a);
      foreach (beats[i]) if (!beats[i].miss && beats[i].idx == int'(a)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cfg_we    = 1'b0;
      flush     = 1'b0;
      pkt_valid = 1'b0;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic cfg(input int a, input int k, input int c, input int d, input int w,
                      input bit v);
      cfg_addr = 4'(a); cfg_key = 4'(k); cfg_care = 4'(c);
      cfg_dst = 4'(d); cfg_weight = 4'(w); cfg_vld = v; cfg_we = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_key = 0; cfg_care = 0; cfg_dst = 0;
      cfg_weight = 0; cfg_vld = 0; flush = 0; pkt_valid = 0; pkt_id = 0; out_ready = 1'b1;
      neg();
      chk("rst_pkt_ready", 16'(pkt_ready), 16'd0);
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      tick(); tick();
      rst = 1'b0;

      // Empty table: single miss beat two cycles after accept.
      pkt_valid = 1'b1; pkt_id = 4'h3;
      neg(); chk("s1_accept", 16'(pkt_ready), 16'd1);
      tick(); neg(); chk("s1_match_gap", 16'(out_valid), 16'd0);
      tick(); neg();
      chk("s1_valid", 16'(out_valid), 16'd1);
      chk("s1_miss", 16'(out_miss), 16'd1);
      chk("s1_last", 16'(out_last), 16'd1);
      chk("s1_dst", 16'(out_dst), 16'd0);
      tick(); neg(); chk("s1_idle", 16'(pkt_ready), 16'd1);

      // Exact entry 2 and wildcard entry 9.
      cfg(2, 3, 15, 7, 5, 1'b1);
      cfg(9, 0, 0, 1, 2, 1'b1);
      pkt_valid = 1'b1; pkt_id = 4'h3;
      tick(); tick(); neg();
      chk("s2_b0_dst", 16'(out_dst), 16'd7);
      chk("s2_b0_wt", 16'(out_weight), 16'd5);
      chk("s2_b0_last", 16'(out_last), 16'd0);
      tick(); neg();
      chk("s2_b1_dst", 16'(out_dst), 16'd1);
      chk("s2_b1_wt", 16'(out_weight), 16'd2);
      chk("s2_b1_last", 16'(out_last), 16'd1);
      tick();

      // Every entry matches; stall five cycles, then drain all sixteen beats.
      for (int i = 0; i < 16; i++) cfg(i, i, 0, i, 15 - i, 1'b1);
      out_ready = 1'b0; pkt_valid = 1'b1; pkt_id = 4'($urandom);
      tick(); tick();
      repeat (5) begin
         neg();
         chk("s3_stall_valid", 16'(out_valid), 16'd1);
         chk("s3_stall_dst", 16'(out_dst), 16'd0);
         chk("s3_stall_ready", 16'(pkt_ready), 16'd0);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         neg();
         chk("s3_dst", 16'(out_dst), 16'(i));
         chk("s3_wt", 16'(out_weight), 16'(15 - i));
         chk("s3_last", 16'(out_last), 16'(i == 15));
         chk("s3_busy", 16'(pkt_ready), 16'd0);
         tick();
      end
      neg(); chk("s3_idle", 16'(pkt_ready), 16'd1);

      // Flush beats a coincident write.
      cfg_addr = 0; cfg_key = 0; cfg_care = 4'hF; cfg_dst = 4'h9; cfg_weight = 4'h9;
      cfg_vld = 1'b1; cfg_we = 1'b1; flush = 1'b1;
      tick();
      pkt_valid = 1'b1; pkt_id = 4'h0;
      tick(); tick(); neg(); chk("s4_miss", 16'(out_miss), 16'd1);
      tick();

      // A write landing during the lookup cycle is not seen by that lookup.
      pkt_valid = 1'b1; pkt_id = 4'h5;
      tick();
      cfg_addr = 4; cfg_key = 4'h5; cfg_care = 4'hF; cfg_dst = 4'h3; cfg_weight = 4'h3;
      cfg_vld = 1'b1; cfg_we = 1'b1;
      tick(); neg(); chk("s5_late_write_miss", 16'(out_miss), 16'd1);
      tick();

      // Reset on the second beat of a three-beat packet.
      cfg(6, 5, 15, 6, 6, 1'b1);
      cfg(8, 5, 15, 8, 8, 1'b1);
      pkt_valid = 1'b1; pkt_id = 4'h5;
      tick(); tick(); neg(); chk("s6_b0_dst", 16'(out_dst), 16'd3);
      tick(); neg(); chk("s6_b1_dst", 16'(out_dst), 16'd6);
      rst = 1'b1;
      tick(); rst = 1'b0;
      neg();
      chk("s6_post_rst_valid", 16'(out_valid), 16'd0);
      chk("s6_post_rst_ready", 16'(pkt_ready), 16'd1);

      // Three packets, one of which misses.
      cfg(1, 1, 15, 1, 1, 1'b1);
      for (int p = 0; p < 3; p++) begin
         pkt_valid = 1'b1; pkt_id = (p == 2) ? 4'h2 : 4'h1;
         tick(); tick(); tick();
      end
`ifdef ROUTE_STATS_EN
      neg();
      chk("stat_pkts", stat_pkts, 16'd3);
      chk("stat_miss", stat_miss, 16'd1);
`endif

      // Randomized traffic; writes avoid entries whose beats are still owed.
      repeat (3000) begin
         rst        = ($urandom_range(0, 299) == 0);
         pkt_valid  = 1'($urandom_range(0, 1));
         pkt_id     = 4'($urandom);
         out_ready  = ($urandom_range(0, 9) < 7);
         flush      = ($urandom_range(0, 49) == 0);
         cfg_addr   = 4'($urandom);
         cfg_key    = 4'($urandom);
         cfg_care   = 4'($urandom & $urandom);
         cfg_dst    = 4'($urandom);
         cfg_weight = 4'($urandom);
         cfg_vld    = ($urandom_range(0, 4) != 0);
         cfg_we     = ($urandom_range(0, 2) == 0) && phase != 1 && !pending(cfg_addr);
         @(posedge clk);
         #1;
      end
      rst = 1'b0; cfg_we = 1'b0; flush = 1'b0; pkt_valid = 1'b0; out_ready = 1'b1;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/tcam_route_mem.md
TCAM_ROUTE_MEM -- requirements
Module: tcam_route_mem

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be:
- ID_WIDTH, 4, packet ID / key width
- DST_WIDTH, 4, destination ID width
- WEIGHT_WIDTH, 4, synaptic weight width
- WORDS, 16, entry count (power of two, 2..256)
- AW, $clog2(WORDS), entry address width
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  entry write strobe
- cfg_addr  in  AW  entry index
- cfg_key  in  ID_WIDTH  match data
- cfg_care  in  ID_WIDTH  care mask (1 = compare bit, 0 = don't care)
- cfg_dst  in  DST_WIDTH  destination written to entry
- cfg_weight  in  WEIGHT_WIDTH  weight written to entry
- cfg_vld  in  1  entry valid bit written
- flush  in  1  clear all entry valid bits
- pkt_valid  in  1  lookup request
- pkt_ready  out  1  lookup accept
- pkt_id  in  ID_WIDTH  lookup key
- out_valid  out  1  result beat valid
- out_ready  in  1  result beat accept
- out_dst  out  DST_WIDTH  matched destination
- out_weight  out  WEIGHT_WIDTH  matched weight
- out_last  out  1  final beat of this packet
- out_miss  out  1  packet matched no entry

Function
REQ-004 Entry i SHALL match when vld[i]=1 and ((pkt_id ^ key[i]) & care[i]) == 0.
REQ-005 FSM states: IDLE, MATCH, EMIT; pkt_ready=1 only in IDLE.
REQ-006 IDLE -> MATCH on pkt_valid&pkt_ready; the key is registered in that cycle.
REQ-007 MATCH SHALL evaluate all entries and register a WORDS-bit hit vector; the next state is EMIT.
REQ-008 Latency: first out_valid SHALL assert exactly 2 cycles after the accept cycle.
REQ-009 EMIT SHALL present one beat per matching entry, in ascending index order.
- The beat carries dst/weight of the lowest set hit bit.
- On out_valid&out_ready that bit clears.
- out_last=1 on the beat with exactly one remaining bit.
REQ-010 If the hit vector is zero, EMIT SHALL present one beat with out_miss=1, out_last=1, out_dst=0 and out_weight=0.
REQ-011 Beat fields SHALL be held stable while out_valid=1 and out_ready=0.
REQ-012 EMIT -> IDLE on the handshake of the out_last beat; the next packet may be accepted the cycle after.
REQ-013 Config writes and flush SHALL be accepted in any state and take effect next cycle.
- They SHALL NOT alter a hit vector already registered.
- A write landing in the MATCH cycle SHALL NOT be visible to that lookup.
REQ-014 When flush and cfg_we coincide, flush SHALL win and the write SHALL be dropped.
REQ-015 All WORDS entries matching SHALL yield WORDS beats with no gap while out_ready=1.

Reset
REQ-016 On rst the block SHALL:
- enter IDLE
- clear all vld bits
- clear the hit vector
- drive out_valid, out_last, out_miss, out_dst and out_weight to 0
- drive pkt_ready to 0 during reset and 1 the cycle after
REQ-017 Reset asserted mid-EMIT SHALL abandon the packet; no further beats for it appear.
REQ-018 Key, care, dst and weight storage need not be reset.

Configuration
REQ-019 With ROUTE_STATS_EN defined, the block SHALL add outputs stat_pkts (16) and stat_miss (16).
- stat_pkts counts accepted packets; stat_miss counts miss beats.
- Both counters saturate at 16'hFFFF and clear only on rst.
REQ-020 Without ROUTE_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-021 Package tcam_route_pkg SHALL hold:
- the state enum
- the entry struct typedef (key, care, dst, weight, vld)
- default width constants
REQ-022 Sub-module tcam_prio_enc SHALL provide lowest-set-bit index, any-set and exactly-one flags for a WORDS-bit vector.

Verification
REQ-023 Directed scenarios:
- Reset, then pkt_id=4'h3 with all entries invalid -> one beat, out_miss=1, out_last=1, 2 cycles after accept.
- Entry 2 (key 3, care F, dst 7, wt 5) and entry 9 (key 0, care 0, dst 1, wt 2); pkt_id=3 -> beats (7,5) then (1,2,last).
- All 16 entries care=0; out_ready held 0 for 5 cycles, then 1 -> 16 stable, ordered beats; pkt_ready low throughout.
- Flush and cfg_we to entry 0 in the same cycle, then lookup -> miss.
- rst asserted on the 2nd beat of a 3-beat packet -> out_valid=0 next cycle, pkt_ready=1 after.
- ROUTE_STATS_EN: 3 packets, 1 miss -> stat_pkts=3, stat_miss=1.
